if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter path.
REQ-002 Parameter IMM_MASK, default 32'hF000_0000, bit k set means opcode k (word[15:11]) carries a 16-bit immediate in the next fetched word.
REQ-003 clk  input  1  the single clock; all state updates on its negative edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  fetch stage presents a word this cycle.
REQ-006 in_word  input  16  instruction or immediate word from instruction memory.
REQ-007 in_pc  input  PC_W  address of in_word.
REQ-008 stall  input  1  decode cannot accept a new instruction; hold outputs.
REQ-009 flush  input  1  jump taken; discard all buffered and partial content.
REQ-010 fetch_hold  output  1  tells fetch not to advance pc this cycle.
REQ-011 out_valid  output  1  out_* fields hold a complete instruction.
REQ-012 out_instr  output  16  instruction word.
REQ-013 out_imm  output  16  immediate word; 0 when out_has_imm=0.
REQ-014 out_has_imm  output  1  instruction carried an immediate.
REQ-015 out_pc  output  PC_W  address of the instruction word (not the immediate).

Function
REQ-016 The block SHALL have states IDLE (no partial instruction) and WAIT_IMM (opcode word captured, immediate pending).
REQ-017 IDLE, in_valid=1, not stall/flush, IMM_MASK[in_word[15:11]]=0: out_instr<=in_word, out_pc<=in_pc, out_imm<=0, out_has_imm<=0, out_valid<=1 on the same edge; latency one edge.
REQ-018 IDLE, in_valid=1, not stall/flush, IMM_MASK bit set: word and pc SHALL go to an internal pending register, out_valid<=0, state<=WAIT_IMM.
REQ-019 WAIT_IMM, in_valid=1, not stall/flush: out_instr<=pending word, out_pc<=pending pc, out_imm<=in_word, out_has_imm<=1, out_valid<=1, state<=IDLE; the immediate word's opcode field SHALL NOT be decoded.
REQ-020 in_valid=0 with no stall/flush: out_valid<=0; state and pending register unchanged.
REQ-021 stall=1 and flush=0: all outputs, state and pending register SHALL hold; in_word SHALL be ignored.
REQ-022 fetch_hold SHALL be combinational and equal stall & ~flush, so no word is lost during a stall.
REQ-023 flush=1: on the next edge out_valid<=0, out_has_imm<=0, state<=IDLE, pending register cleared; in_word that cycle discarded regardless of in_valid.
REQ-024 flush and stall both 1: flush SHALL win (REQ-023), fetch_hold=0.
REQ-025 out_pc SHALL be a PC_W-bit copy with no arithmetic; wrap-around is the fetch stage's concern.
REQ-026 Back-to-back non-immediate words SHALL yield out_valid=1 on consecutive edges (throughput one instruction per cycle); immediate instructions yield one per two cycles.

Reset
REQ-027 While rst=1, independent of clk: state=IDLE, out_valid=0, out_instr=0, out_imm=0, out_has_imm=0, out_pc=0, pending register=0; fetch_hold follows REQ-022.
REQ-028 Reset asserted in WAIT_IMM SHALL discard the pending word; the first post-reset word is decoded as an opcode.
REQ-029 First capture after reset SHALL occur on the first negedge with rst=0 and in_valid=1.

Verification
REQ-030 Reset then in_word=16'h0123, in_pc=32, in_valid=1 for one edge -> out_valid=1, out_instr=16'h0123, out_pc=32, out_has_imm=0.
REQ-031 in_word=16'hF805 (opcode 31) pc=40, then 16'hBEEF pc=41 -> after edge 1 out_valid=0; after edge 2 out_instr=16'hF805, out_imm=16'hBEEF, out_pc=40, out_has_imm=1.
REQ-032 Valid out_instr=16'h0011, then stall=1 for 3 cycles with in_word=16'h0022 -> outputs frozen at 16'h0011, fetch_hold=1; after release 16'h0022 captured next edge.
REQ-033 Opcode-31 word captured (WAIT_IMM), next cycle flush=1 with in_word=16'h1234 -> out_valid=0, state IDLE; next word 16'h0042 appears as out_instr with out_has_imm=0.
REQ-034 stall=1 and flush=1 same cycle -> fetch_hold=0, out_valid=0 after the edge.
REQ-035 rst pulsed asynchronously mid-cycle while in WAIT_IMM -> all outputs 0 immediately, following word 16'h0100 decoded as a plain instruction.

Source files
------------

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch/decode pipeline register that joins an opcode word with its trailing 16-bit immediate.
module if_id_buffer #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] IMM_MASK = 32'hF000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [15:0]     in_word,
  input  logic [PC_W-1:0] in_pc,
  input  logic            stall,
  input  logic            flush,
  output logic            fetch_hold,
  output logic            out_valid,
  output logic [15:0]     out_instr,
  output logic [15:0]     out_imm,
  output logic            out_has_imm,
  output logic [PC_W-1:0] out_pc
);
  typedef enum logic {IDLE, WAIT_IMM} state_t;
  state_t            state;
  logic [15:0]       pend_word;
  logic [PC_W-1:0]   pend_pc;
  assign fetch_hold = stall & ~flush;
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_word   <= '0;
      pend_pc     <= '0;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_imm     <= '0;
      out_has_imm <= 1'b0;
      out_pc      <= '0;
    end else if (flush) begin
      state       <= IDLE;
      pend_word   <= '0;
      pend_pc     <= '0;
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_has_imm <= 1'b0;
    end else if (!stall) begin
      if (!in_valid) begin
        out_valid <= 1'b0;
      end else if (state == WAIT_IMM) begin
        out_instr   <= pend_word;
        out_pc      <= pend_pc;
        out_imm     <= in_word;
        out_has_imm <= 1'b1;
        out_valid   <= 1'b1;
        state       <= IDLE;
      end else if (IMM_MASK[in_word[15:11]]) begin
        pend_word <= in_word;
        pend_pc   <= in_pc;
        out_valid <= 1'b0;
        state     <= WAIT_IMM;
      end else begin
        out_instr   <= in_word;
        out_pc      <= in_pc;
        out_imm     <= '0;
        out_has_imm <= 1'b0;
        out_valid   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed and random scenarios with a scoreboard of expected instructions.
module tb_if_id_buffer;
  localparam logic [31:0] IMM_MASK = 32'hF000_0000;
  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has;
    logic [31:0] pc;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [15:0] in_word;
  logic [31:0] in_pc;
  logic        fetch_hold, out_valid, out_has_imm;
  logic [15:0] out_instr, out_imm;
  logic [31:0] out_pc;
  int          vecs = 0;
  int          errs = 0;
  exp_t        q[$];
  logic        emit = 1'b0;
  logic        mon_e;
  exp_t        mon_x;
  logic        mw = 1'b0;
  logic        mv = 1'b0;
  logic [15:0] m_word;
  logic [31:0] m_pc;
  if_id_buffer #(.PC_W(32), .IMM_MASK(IMM_MASK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_pc(in_pc),
    .stall(stall), .flush(flush), .fetch_hold(fetch_hold), .out_valid(out_valid),
    .out_instr(out_instr), .out_imm(out_imm), .out_has_imm(out_has_imm), .out_pc(out_pc)
  );
  always #5 clk = ~clk;
  // The scoreboard pops only when the reference expects a freshly completed instruction.
  always @(negedge clk) begin
    mon_e = emit;
    #2;
    if (mon_e) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL sb_underflow: out_valid=%b but no expected instruction", out_valid);
      end else begin
        mon_x = q.pop_front();
        if ({out_valid, out_instr, out_imm, out_has_imm, out_pc} !== {1'b1, mon_x.instr, mon_x.imm, mon_x.has, mon_x.pc}) begin
          errs++;
          $display("FAIL sb_out: got v=%b i=%h m=%h h=%b pc=%0d want v=1 i=%h m=%h h=%b pc=%0d",
                   out_valid, out_instr, out_imm, out_has_imm, out_pc, mon_x.instr, mon_x.imm, mon_x.has, mon_x.pc);
        end
      end
    end
  end
  task automatic cycle(input logic v, input logic [15:0] w, input logic [31:0] p, input logic s, input logic f);
    in_valid = v; in_word = w; in_pc = p; stall = s; flush = f; emit = 1'b0;
    if (f) begin
      mw = 1'b0; mv = 1'b0;
    end else if (s) begin
    end else if (!v) begin
      mv = 1'b0;
    end else if (mw) begin
      q.push_back('{m_word, w, 1'b1, m_pc}); mw = 1'b0; mv = 1'b1; emit = 1'b1;
    end else if (IMM_MASK[w[15:11]]) begin
      m_word = w; m_pc = p; mw = 1'b1; mv = 1'b0;
    end else begin
      q.push_back('{w, 16'h0, 1'b0, p}); mv = 1'b1; emit = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset;
    emit = 1'b0; rst = 1'b1; in_valid = 1'b1; in_word = 16'h5555; in_pc = 32'd7; stall = 1'b1; flush = 1'b0;
    #3;
    vecs++;
    if ({out_valid, out_instr, out_imm, out_has_imm, out_pc} !== 66'h0) begin
      errs++; $display("FAIL reset_outputs: got v=%b i=%h m=%h h=%b pc=%0d want all 0", out_valid, out_instr, out_imm, out_has_imm, out_pc);
    end
    vecs++;
    if (fetch_hold !== 1'b1) begin errs++; $display("FAIL reset_fetch_hold: got %b want 1", fetch_hold); end
    @(negedge clk); #1;
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_hold_edge: out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0; mw = 1'b0; mv = 1'b0;
  endtask
  task automatic test_plain;
    cycle(1, 16'h0123, 32, 0, 0);
    vecs++;
    if ({out_valid, out_instr, out_pc, out_has_imm} !== {1'b1, 16'h0123, 32'd32, 1'b0}) begin
      errs++; $display("FAIL plain: got v=%b i=%h pc=%0d h=%b want v=1 i=0123 pc=32 h=0", out_valid, out_instr, out_pc, out_has_imm);
    end
  endtask
  task automatic test_imm;
    cycle(1, 16'hF805, 40, 0, 0);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL imm_first: out_valid got %b want 0", out_valid); end
    cycle(1, 16'hBEEF, 41, 0, 0);
    vecs++;
    if ({out_valid, out_instr, out_imm, out_pc, out_has_imm} !== {1'b1, 16'hF805, 16'hBEEF, 32'd40, 1'b1}) begin
      errs++; $display("FAIL imm_pair: got v=%b i=%h m=%h pc=%0d h=%b want v=1 i=F805 m=BEEF pc=40 h=1", out_valid, out_instr, out_imm, out_pc, out_has_imm);
    end
    cycle(1, 16'hE001, 42, 0, 0);
    cycle(0, 16'h0000, 43, 0, 0);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL imm_bubble: out_valid got %b want 0", out_valid); end
    cycle(1, 16'hF8AA, 44, 0, 0);
    vecs++;
    if ({out_valid, out_instr, out_imm, out_pc} !== {1'b1, 16'hE001, 16'hF8AA, 32'd42}) begin
      errs++; $display("FAIL imm_opcode_not_decoded: got v=%b i=%h m=%h pc=%0d want v=1 i=E001 m=F8AA pc=42", out_valid, out_instr, out_imm, out_pc);
    end
  endtask
  task automatic test_stall;
    cycle(1, 16'h0011, 50, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 16'h0022, 51, 1, 0);
      vecs++;
      if ({fetch_hold, out_valid, out_instr, out_pc} !== {1'b1, 1'b1, 16'h0011, 32'd50}) begin
        errs++; $display("FAIL stall_hold%0d: got fh=%b v=%b i=%h pc=%0d want fh=1 v=1 i=0011 pc=50", i, fetch_hold, out_valid, out_instr, out_pc);
      end
    end
    cycle(1, 16'h0022, 51, 0, 0);
    vecs++;
    if ({fetch_hold, out_valid, out_instr, out_pc} !== {1'b0, 1'b1, 16'h0022, 32'd51}) begin
      errs++; $display("FAIL stall_release: got fh=%b v=%b i=%h pc=%0d want fh=0 v=1 i=0022 pc=51", fetch_hold, out_valid, out_instr, out_pc);
    end
  endtask
  task automatic test_flush;
    cycle(1, 16'hF805, 60, 0, 0);
    cycle(1, 16'h1234, 61, 0, 1);
    vecs++;
    if ({out_valid, out_has_imm} !== 2'b00) begin
      errs++; $display("FAIL flush_clear: got v=%b h=%b want v=0 h=0", out_valid, out_has_imm);
    end
    cycle(1, 16'h0042, 62, 0, 0);
    vecs++;
    if ({out_valid, out_instr, out_has_imm, out_pc} !== {1'b1, 16'h0042, 1'b0, 32'd62}) begin
      errs++; $display("FAIL flush_next: got v=%b i=%h h=%b pc=%0d want v=1 i=0042 h=0 pc=62", out_valid, out_instr, out_has_imm, out_pc);
    end
  endtask
  task automatic test_stall_flush;
    cycle(1, 16'hF805, 70, 0, 0);
    in_valid = 1'b1; in_word = 16'hAAAA; stall = 1'b1; flush = 1'b1;
    #1;
    vecs++;
    if (fetch_hold !== 1'b0) begin errs++; $display("FAIL stall_flush_fh: got %b want 0", fetch_hold); end
    cycle(1, 16'hAAAA, 71, 1, 1);
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL stall_flush_valid: got %b want 0", out_valid); end
    cycle(1, 16'h0077, 72, 0, 0);
    vecs++;
    if ({out_valid, out_instr, out_has_imm} !== {1'b1, 16'h0077, 1'b0}) begin
      errs++; $display("FAIL stall_flush_next: got v=%b i=%h h=%b want v=1 i=0077 h=0", out_valid, out_instr, out_has_imm);
    end
  endtask
  task automatic test_async_reset;
    cycle(1, 16'hF805, 80, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if ({out_valid, out_instr, out_imm, out_has_imm, out_pc} !== 66'h0) begin
      errs++; $display("FAIL async_reset: got v=%b i=%h m=%h h=%b pc=%0d want all 0", out_valid, out_instr, out_imm, out_has_imm, out_pc);
    end
    mw = 1'b0; mv = 1'b0;
    #2;
    rst = 1'b0;
    cycle(1, 16'h0100, 90, 0, 0);
    vecs++;
    if ({out_valid, out_instr, out_has_imm, out_pc} !== {1'b1, 16'h0100, 1'b0, 32'd90}) begin
      errs++; $display("FAIL async_reset_next: got v=%b i=%h h=%b pc=%0d want v=1 i=0100 h=0 pc=90", out_valid, out_instr, out_has_imm, out_pc);
    end
  endtask
  task automatic test_back_to_back;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) begin
      w = {5'($urandom_range(0, 27)), 11'($urandom)};
      cycle(1, w, 32'(100 + i), 0, 0);
      vecs++;
      if ({out_valid, out_instr} !== {1'b1, w}) begin
        errs++; $display("FAIL b2b%0d: got v=%b i=%h want v=1 i=%h", i, out_valid, out_instr, w);
      end
    end
  endtask
  task automatic test_random;
    logic v, s, f;
    for (int i = 0; i < 60; i++) begin
      v = $urandom_range(0, 3) != 0;
      s = $urandom_range(0, 4) == 0;
      f = $urandom_range(0, 11) == 0;
      cycle(v, 16'($urandom), 32'(200 + i), s, f);
      vecs++;
      if ({out_valid, fetch_hold} !== {mv, s & ~f}) begin
        errs++; $display("FAIL rand%0d: got v=%b fh=%b want v=%b fh=%b", i, out_valid, fetch_hold, mv, s & ~f);
      end
    end
    cycle(0, 16'h0, 0, 0, 0);
    #2;
    vecs++;
    if (q.size() != 0) begin errs++; $display("FAIL sb_leftover: got %0d pending want 0", q.size()); end
  endtask
  initial begin
    test_reset;
    test_plain;
    test_imm;
    test_stall;
    test_flush;
    test_stall_flush;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
